// File: rtl/voice_sched.sv
// voice_sched: sequences up to three voices through one envelope unit per sample tick and sums their outputs.
module voice_sched #(
  parameter int NUM_VOICES = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sample_tick_i,
  input  logic [2:0]  gate_i,
  input  logic [11:0] attack_i,
  input  logic [11:0] decay_i,
  input  logic [11:0] sustain_i,
  input  logic [11:0] release_i,
  output logic        env_start_o,
  output logic [1:0]  env_voice_idx_o,
  output logic        env_gate_o,
  output logic [3:0]  env_attack_o,
  output logic [3:0]  env_decay_o,
  output logic [3:0]  env_sustain_o,
  output logic [3:0]  env_release_o,
  input  logic        env_ready_i,
  input  logic [9:0]  env_wave_i,
  output logic [11:0] mix_o,
  output logic        mix_valid_o,
  output logic        busy_o,
  output logic        overrun_o,
  input  logic        clr_overrun_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  localparam logic [1:0] LAST = 2'(NUM_VOICES - 1);
  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] acc_q, acc_d, mix_q, mix_d;
  logic        mix_valid_q, mix_valid_d, overrun_q, overrun_d;
  logic [3:0]  sel;
  assign sel             = {idx_q, 2'b00};
  assign env_start_o     = state_q == ISSUE;
  assign busy_o          = state_q != IDLE;
  assign env_voice_idx_o = idx_q;
  assign env_gate_o      = 1'(gate_i >> idx_q);
  assign env_attack_o    = 4'(attack_i >> sel);
  assign env_decay_o     = 4'(decay_i >> sel);
  assign env_sustain_o   = 4'(sustain_i >> sel);
  assign env_release_o   = 4'(release_i >> sel);
  assign mix_o           = mix_q;
  assign mix_valid_o     = mix_valid_q;
  assign overrun_o       = overrun_q;
  // Next-state: frame sequencing, accumulation and sticky overrun (set wins over clear).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    overrun_d   = (sample_tick_i && state_q != IDLE) ? 1'b1 : clr_overrun_i ? 1'b0 : overrun_q;
    case (state_q)
      IDLE: if (sample_tick_i) begin
        state_d = ISSUE;
        idx_d   = 2'd0;
        acc_d   = 12'd0;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (env_ready_i) begin
        acc_d   = acc_q + {2'b00, env_wave_i};
        state_d = (idx_q < LAST) ? ISSUE : DONE;
        idx_d   = (idx_q < LAST) ? idx_q + 2'd1 : idx_q;
      end
      DONE: begin
        mix_d       = acc_q;
        mix_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      acc_q       <= 12'd0;
      mix_q       <= 12'd0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
    end
  end
endmodule

// File: tb/tb_voice_sched.sv
// tb_voice_sched: randomized frames against a sum/latency model with a behavioural envelope responder.
module tb_voice_sched;
  logic clk_i = 0, rst_ni = 0, tick = 0, clr = 0, tick1 = 0;
  logic [2:0] gate = 0;
  logic [11:0] atk = 0, dec = 0, sus = 0, rel = 0;
  logic resp_ready = 0, stray = 0, ready1 = 0, stray1 = 0, rdy, rdy1;
  logic [9:0] wave = 0, wave1 = 0;
  logic start, egate, mv, busy, ovr, start1, egate1, mv1, busy1, ovr1;
  logic [1:0] idx, idx1;
  logic [3:0] ea, ed, es, er, ea1, ed1, es1, er1;
  logic [11:0] mix, mix1;
  int tests = 0, fails = 0;
  int waves[3];
  int dly = 3, starts = 0, cur = 0, cnt = 0, mv_cnt = 0;
  int w1 = 0, starts1 = 0, cnt1 = 0, mv1_cnt = 0;
  bit pend = 0, pend1 = 0;
  assign rdy  = resp_ready | stray;
  assign rdy1 = ready1 | stray1;
  always #5 clk_i = ~clk_i;

  voice_sched #(.NUM_VOICES(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sample_tick_i(tick), .gate_i(gate),
    .attack_i(atk), .decay_i(dec), .sustain_i(sus), .release_i(rel),
    .env_start_o(start), .env_voice_idx_o(idx), .env_gate_o(egate),
    .env_attack_o(ea), .env_decay_o(ed), .env_sustain_o(es), .env_release_o(er),
    .env_ready_i(rdy), .env_wave_i(wave), .mix_o(mix), .mix_valid_o(mv),
    .busy_o(busy), .overrun_o(ovr), .clr_overrun_i(clr));

  voice_sched #(.NUM_VOICES(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .sample_tick_i(tick1), .gate_i(gate),
    .attack_i(atk), .decay_i(dec), .sustain_i(sus), .release_i(rel),
    .env_start_o(start1), .env_voice_idx_o(idx1), .env_gate_o(egate1),
    .env_attack_o(ea1), .env_decay_o(ed1), .env_sustain_o(es1), .env_release_o(er1),
    .env_ready_i(rdy1), .env_wave_i(wave1), .mix_o(mix1), .mix_valid_o(mv1),
    .busy_o(busy1), .overrun_o(ovr1), .clr_overrun_i(1'b0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (mv === 1'b1) mv_cnt++;
    if (mv1 === 1'b1) mv1_cnt++;
  end

  // Envelope unit model for the 3-voice DUT: answers each start after dly cycles with that voice's wave.
  always begin
    @(posedge clk_i); #1;
    resp_ready = 1'b0;
    if (!rst_ni) pend = 0;
    else begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          resp_ready = 1'b1;
          pend = 0;
          chk("idx_at_ready", idx, cur);
        end
      end
      if (start) begin
        cur = starts;
        starts++;
        pend = 1;
        cnt = dly;
        chk("start_idx", idx, cur);
        chk("gate_mux", egate, (gate >> cur) & 1);
        chk("attack_mux", ea, (atk >> (4 * cur)) & 15);
        chk("decay_mux", ed, (dec >> (4 * cur)) & 15);
        chk("sustain_mux", es, (sus >> (4 * cur)) & 15);
        chk("release_mux", er, (rel >> (4 * cur)) & 15);
      end
    end
    wave = resp_ready ? 10'(waves[cur]) : 10'($urandom);
  end

  // Envelope unit model for the 1-voice DUT: fixed two-cycle response.
  always begin
    @(posedge clk_i); #1;
    ready1 = 1'b0;
    if (!rst_ni) pend1 = 0;
    else begin
      if (pend1) begin
        cnt1--;
        if (cnt1 == 0) begin
          ready1 = 1'b1;
          pend1 = 0;
        end
      end
      if (start1) begin
        starts1++;
        pend1 = 1;
        cnt1 = 2;
      end
    end
    wave1 = ready1 ? 10'(w1) : 10'($urandom);
  end

  task automatic frame3(input int mode);
    int exp_lat, lat, mv0;
    exp_lat = 1 + 3 * (1 + dly) + 1;
    starts = 0;
    mv0 = mv_cnt;
    tick = 1;
    @(posedge clk_i); #1;
    tick = 0;
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
      if (mode == 1 && lat == 4) tick = 1;
      if (mode == 1 && lat == 5) begin
        tick = 0;
        chk("overrun_set", ovr, 1);
      end
      if (mode == 2 && (lat == 2 || lat == 6)) begin
        tick = 1;
        clr = 1;
      end
      if (mode == 2 && (lat == 3 || lat == 7)) begin
        tick = 0;
        clr = 0;
        chk("set_beats_clr", ovr, 1);
      end
      if (mode == 2 && (lat == 4 || lat == 8)) clr = 1;
      if (mode == 2 && (lat == 5 || lat == 9)) begin
        clr = 0;
        chk("lone_clr", ovr, 0);
      end
      if (mode == 3 && lat == exp_lat - 2) tick = 1;
      if (mode == 3 && lat == exp_lat - 1) tick = 0;
    end while (mv !== 1'b1 && lat < 200);
    chk("latency", lat + 1, exp_lat);
    chk("mix", mix, waves[0] + waves[1] + waves[2]);
    chk("starts", starts, 3);
    if (mode == 3) chk("overrun_in_done", ovr, 1);
    @(posedge clk_i); #1;
    chk("mv_single", mv, 0);
    chk("mv_count", mv_cnt - mv0, 1);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int mv0, lat;
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int mv0, lat;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_mix", mix, 0);
    chk("rst_mv", mv, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_idx", idx, 0);
    rst_ni = 1;
    @(posedge clk_i); #1;
    waves = '{100, 200, 300};
    dly = 3;
    frame3(0);
    waves = '{1023, 1023, 1023};
    frame3(0);
    gate = 3'b101;
    atk = 12'h3A7;
    dec = 12'h5C1;
    sus = 12'hE20;
    rel = 12'h9F4;
    waves = '{7, 0, 512};
    frame3(0);
    for (int f = 0; f < 20; f++) begin
      for (int v = 0; v < 3; v++) waves[v] = $urandom_range(0, 1023);
      dly = $urandom_range(1, 5);
      gate = 3'($urandom);
      atk = 12'($urandom);
      dec = 12'($urandom);
      sus = 12'($urandom);
      rel = 12'($urandom);
      repeat ($urandom_range(0, 3)) begin
        stray = 1'($urandom);
        @(posedge clk_i); #1;
        chk("stray_idle", busy, 0);
      end
      stray = 0;
      frame3(0);
    end
    dly = 3;
    for (int m = 1; m <= 3; m++) begin
      for (int v = 0; v < 3; v++) waves[v] = $urandom_range(0, 1023);
      if (m == 3) begin
        clr = 1;
        @(posedge clk_i); #1;
        clr = 0;
        chk("clr_before_done", ovr, 0);
      end
      frame3(m);
    end
    dly = 5;
    for (int v = 0; v < 3; v++) waves[v] = $urandom_range(1, 1023);
    starts = 0;
    mv0 = mv_cnt;
    tick = 1;
    @(posedge clk_i); #1;
    tick = 0;
    for (int i = 0; i < 40 && starts < 2; i++) begin
      @(posedge clk_i); #1;
    end
    chk("reached_v1", starts, 2);
    tick = 1;
    @(posedge clk_i); #1;
    tick = 0;
    chk("ovr_before_rst", ovr, 1);
    rst_ni = 0;
    #1;
    chk("midrst_mix", mix, 0);
    chk("midrst_mv", mv, 0);
    chk("midrst_start", start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovr", ovr, 0);
    chk("midrst_idx", idx, 0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    repeat (20) @(posedge clk_i);
    #1;
    chk("no_mv_after_rst", mv_cnt - mv0, 0);
    chk("idle_after_rst", busy, 0);
    dly = 2;
    for (int v = 0; v < 3; v++) waves[v] = $urandom_range(0, 1023);
    frame3(0);
    for (int f = 0; f < 3; f++) begin
      w1 = (f == 0) ? 1023 : $urandom_range(0, 1023);
      starts1 = 0;
      repeat (4) begin
        stray1 = 1'($urandom);
        @(posedge clk_i); #1;
        chk("n1_stray_idle", busy1, 0);
      end
      stray1 = 1;
      @(posedge clk_i); #1;
      stray1 = 0;
      chk("n1_stray_busy", busy1, 0);
      chk("n1_no_stray_start", starts1, 0);
      mv0 = mv1_cnt;
      tick1 = 1;
      @(posedge clk_i); #1;
      tick1 = 0;
      lat = 0;
      do begin
        @(posedge clk_i); #1;
        lat++;
      end while (mv1 !== 1'b1 && lat < 100);
      chk("n1_latency", lat + 1, 5);
      chk("n1_mix", mix1, w1);
      chk("n1_starts", starts1, 1);
      @(posedge clk_i); #1;
      chk("n1_mv_single", mv1_cnt - mv0, 1);
      chk("n1_idle", busy1, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/voice_sched.md
VOICE_SCHED -- requirements
Module: voice_sched

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, number of voices sequenced per sample tick; legal values 1..3.
REQ-002 SHALL have port clk_i  input  1  clock.
REQ-003 SHALL have port rst_ni  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port sample_tick_i  input  1  one-cycle pulse requesting a new sample frame.
REQ-005 SHALL have port gate_i  input  3  per-voice gate; bit v belongs to voice v.
REQ-006 SHALL have port attack_i  input  12  per-voice attack; nibble [4v+3:4v] belongs to voice v.
REQ-007 SHALL have ports decay_i, sustain_i and release_i  input  12 each  per-voice, packed the same way as attack_i.
REQ-008 SHALL have port env_start_o  output  1  start pulse to the envelope unit.
REQ-009 SHALL have port env_voice_idx_o  output  2  active voice index.
REQ-010 SHALL have port env_gate_o  output  1  gate of the active voice.
REQ-011 SHALL have ports env_attack_o, env_decay_o, env_sustain_o and env_release_o  output  4 each  ADSR nibbles of the active voice.
REQ-012 SHALL have port env_ready_i  input  1  envelope unit done; env_wave_i is valid in the same cycle.
REQ-013 SHALL have port env_wave_i  input  10  unsigned scaled voice sample.
REQ-014 SHALL have port mix_o  output  12  unsigned sum of all voices for the last frame.
REQ-015 SHALL have port mix_valid_o  output  1  one-cycle pulse when mix_o updates.
REQ-016 SHALL have port busy_o  output  1  high whenever the state is not IDLE.
REQ-017 SHALL have port overrun_o  output  1  sticky flag: a tick arrived while busy.
REQ-018 SHALL have port clr_overrun_i  input  1  clears overrun_o.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT and DONE.
REQ-020 SHALL move from IDLE to ISSUE on sample_tick_i, loading idx=0 and acc=0 in the same edge.
REQ-021 SHALL drive env_start_o high for exactly one cycle while in ISSUE, then move to WAIT.
REQ-022 SHALL remain in WAIT until env_ready_i=1; in that cycle it SHALL add env_wave_i, zero-extended to 12 bits, to acc.
REQ-023 SHALL, on ready in WAIT, go to ISSUE with idx+1 if idx<NUM_VOICES-1, otherwise go to DONE.
REQ-024 SHALL, in DONE, register mix_o<=acc, pulse mix_valid_o for one cycle and return to IDLE.
REQ-025 SHALL drive env_voice_idx_o from registered idx, stable from ISSUE through the ready cycle.
REQ-026 SHALL drive the env_gate_o and ADSR outputs combinationally as the voice-idx slice of gate_i and the ADSR inputs.
REQ-027 SHALL use 12-bit acc arithmetic with no saturation needed (maximum 3*1023=3069).
REQ-028 SHALL make frame latency, from tick to mix_valid_o, equal to 1+NUM_VOICES*(1+W)+1 cycles, where W is the number of WAIT cycles per voice including the ready cycle; with W=3, NUM_VOICES=3 this is 14 cycles.
REQ-029 SHALL ignore sample_tick_i in any non-IDLE state (including DONE) and set overrun_o instead.
REQ-030 SHALL give set priority over clr_overrun_i when both occur in the same cycle.
REQ-031 SHALL ignore env_ready_i outside WAIT, with no effect on acc or state.
REQ-032 SHALL NOT issue env_start_o in any state other than ISSUE.
REQ-033 SHALL hold mix_o between frames, changing it only in DONE.

Reset
REQ-034 SHALL, on rst_ni low, asynchronously force state=IDLE, idx=0, acc=0, mix_o=0, mix_valid_o=0, env_start_o=0, busy_o=0 and overrun_o=0.
REQ-035 SHALL, on reset mid-frame, abandon the frame without producing mix_valid_o; the first tick after release SHALL start a fresh frame at voice 0.

Verification
REQ-036 Normal frame: model ready 3 cycles after each start, waves 100/200/300, tick -> starts with idx 0,1,2; mix_o=600; single mix_valid_o 14 cycles after tick.
REQ-037 Full-scale: waves 1023 x3 -> mix_o=3069, no wrap.
REQ-038 Overrun: second tick 5 cycles after the first -> overrun_o=1 and the frame completes unchanged; clr_overrun_i together with a new busy tick -> overrun_o stays 1; a lone clr -> 0.
REQ-039 Muxing: gate_i=3'b101, attack_i=12'h3A7 -> during voices 0/1/2, env_gate_o=1/0/1 and env_attack_o=7/A/3.
REQ-040 Reset in WAIT of voice 1 -> all outputs 0 and no mix_valid_o; the next tick starts at idx 0 and gives the correct sum.
REQ-041 NUM_VOICES=1, stray env_ready_i pulses while IDLE -> one start per tick, mix_o equals the voice-0 wave, and no spurious state change.
